// File: rtl/rfdc_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// rfdc_wb_arbiter_if
//   Bundles the NM upstream Wishbone master ports and the single downstream
//   RFDC Wishbone target port that rfdc_wb_arbiter sits between.
//
//   Upstream (per master k, packed at k*WIDTH +: WIDTH):
//     m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i  requests
//     m_dat_o (shared), m_ack_o, m_err_o                   responses
//   Downstream (RFDC WB target):
//     s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o  request
//     s_dat_i, s_ack_i, s_err_i                            response
//
//   Modports:
//     master : the arbiter's view; it masters the RFDC target port and
//              answers the upstream masters.
//     slave  : the surrounding world's view (upstream masters plus the
//              RFDC target), i.e. everything the arbiter talks to.
// ---------------------------------------------------------------------------
interface rfdc_wb_arbiter_if #(
    parameter int NM        = 2,
    parameter int ADDR_BITS = 18,
    parameter int DATA_BITS = 32
);
    localparam int SEL_BITS = DATA_BITS / 8;

    logic [NM-1:0]           m_cyc_i;
    logic [NM-1:0]           m_stb_i;
    logic [NM-1:0]           m_we_i;
    logic [NM*ADDR_BITS-1:0] m_adr_i;
    logic [NM*DATA_BITS-1:0] m_dat_i;
    logic [NM*SEL_BITS-1:0]  m_sel_i;
    logic [DATA_BITS-1:0]    m_dat_o;
    logic [NM-1:0]           m_ack_o;
    logic [NM-1:0]           m_err_o;

    logic                    s_cyc_o;
    logic                    s_stb_o;
    logic                    s_we_o;
    logic [ADDR_BITS-1:0]    s_adr_o;
    logic [DATA_BITS-1:0]    s_dat_o;
    logic [SEL_BITS-1:0]     s_sel_o;
    logic [DATA_BITS-1:0]    s_dat_i;
    logic                    s_ack_i;
    logic                    s_err_i;

    modport master (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_dat_i, s_ack_i, s_err_i
    );

    modport slave (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output s_dat_i, s_ack_i, s_err_i
    );

endinterface

// File: rtl/rfdc_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rfdc_wb_arbiter
//   Shares the single Wishbone register port of the RFDC wrapper between NM
//   Wishbone masters (e.g. housekeeping/serial-command path and the
//   auto-configuration sequencer). Round-robin, one transaction per grant,
//   fully registered, with a watchdog that aborts a transaction the
//   WB->AXI bridge never answers.
//
// Ports:
//   wb_clk_i      clock for all logic
//   wb_rst_i      synchronous active-high reset
//   bus           rfdc_wb_arbiter_if.master: upstream masters + RFDC target
//   bridge_err_i  bridge error pulse from the RFDC wrapper
//   grant_o       one-hot current owner, 0 when idle
//   timeout_o     one-cycle pulse on watchdog abort
//   err_count_o   saturating count of timeouts plus bridge errors
//
// State | meaning
//   IDLE    | sample requests, pick next owner at/after the pointer
//   ISSUE   | first cycle of the slave strobe, watchdog cleared
//   WAIT    | strobe held until slave ack/err or watchdog expiry
//   RELEASE | response pulse visible, grant dropped, pointer advanced
// ---------------------------------------------------------------------------
module rfdc_wb_arbiter #(
    parameter int NM        = 2,
    parameter int ADDR_BITS = 18,
    parameter int DATA_BITS = 32,
    parameter int TIMEOUT   = 1023
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    rfdc_wb_arbiter_if.master     bus,
    input  logic                  bridge_err_i,
    output logic [NM-1:0]         grant_o,
    output logic                  timeout_o,
    output logic [15:0]           err_count_o
);

    localparam int SEL_BITS = DATA_BITS / 8;
    localparam int IW       = (NM > 1) ? $clog2(NM) : 1;
    localparam int WW       = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] owner;
    logic [WW-1:0] wdog;
    // Owner dropped m_cyc_i at some point after its grant; the slave cycle
    // still completes but its response must not be forwarded.
    logic          aborted;

    logic [NM-1:0] req;
    logic          pick_valid;
    logic [IW-1:0] pick;
    logic [IW:0]   cand;
    logic          owner_live;

    assign req        = bus.m_cyc_i & bus.m_stb_i;
    assign owner_live = !aborted && bus.m_cyc_i[owner];

    // Round-robin search: first requester at or after ptr, wrapping mod NM.
    // ptr and i are both below NM, so one conditional subtract suffices.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int i = 0; i < NM; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(NM)) begin
                cand = cand - (IW+1)'(NM);
            end
            if (!pick_valid && req[cand[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick       = cand[IW-1:0];
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            wdog        <= '0;
            aborted     <= 1'b0;
            grant_o     <= '0;
            timeout_o   <= 1'b0;
            err_count_o <= '0;
            bus.m_dat_o <= '0;
            bus.m_ack_o <= '0;
            bus.m_err_o <= '0;
            bus.s_cyc_o <= 1'b0;
            bus.s_stb_o <= 1'b0;
            bus.s_we_o  <= 1'b0;
            bus.s_adr_o <= '0;
            bus.s_dat_o <= '0;
            bus.s_sel_o <= '0;
        end else begin
            // A timeout and a bridge error in the same cycle count once.
            if ((timeout_o || bridge_err_i) && (err_count_o != 16'hFFFF)) begin
                err_count_o <= err_count_o + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner       <= pick;
                        grant_o     <= NM'(1) << pick;
                        aborted     <= 1'b0;
                        bus.s_we_o  <= bus.m_we_i[pick];
                        bus.s_adr_o <= bus.m_adr_i[int'(pick)*ADDR_BITS +: ADDR_BITS];
                        bus.s_dat_o <= bus.m_dat_i[int'(pick)*DATA_BITS +: DATA_BITS];
                        bus.s_sel_o <= bus.m_sel_i[int'(pick)*SEL_BITS +: SEL_BITS];
                        bus.s_cyc_o <= 1'b1;
                        bus.s_stb_o <= 1'b1;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    wdog <= '0;
                    if (!bus.m_cyc_i[owner]) begin
                        aborted <= 1'b1;
                    end
                    state <= WAIT;
                end

                WAIT: begin
                    if (bus.s_ack_i || bus.s_err_i) begin
                        bus.s_cyc_o <= 1'b0;
                        bus.s_stb_o <= 1'b0;
                        bus.m_dat_o <= bus.s_dat_i;
                        if (owner_live) begin
                            if (bus.s_err_i) begin
                                bus.m_err_o <= grant_o;
                            end else begin
                                bus.m_ack_o <= grant_o;
                            end
                        end
                        state <= RELEASE;
                    end else if (wdog == WW'(TIMEOUT - 1)) begin
                        // TIMEOUT full cycles in WAIT without a response.
                        bus.s_cyc_o <= 1'b0;
                        bus.s_stb_o <= 1'b0;
                        timeout_o   <= 1'b1;
                        if (owner_live) begin
                            bus.m_err_o <= grant_o;
                        end
                        state <= RELEASE;
                    end else begin
                        wdog <= wdog + 1'b1;
                        if (!bus.m_cyc_i[owner]) begin
                            aborted <= 1'b1;
                        end
                    end
                end

                RELEASE: begin
                    bus.m_ack_o <= '0;
                    bus.m_err_o <= '0;
                    timeout_o   <= 1'b0;
                    grant_o     <= '0;
                    ptr         <= (owner == IW'(NM - 1)) ? '0 : owner + 1'b1;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rfdc_wb_arbiter.sv
module tb_rfdc_wb_arbiter;

    localparam int NM = 2;
    localparam int AB = 18;
    localparam int DB = 32;
    localparam int SB = DB / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bridge = 1'b0;
    logic [NM-1:0] grant;
    logic          tmo;
    logic [15:0]   ecnt;

    rfdc_wb_arbiter_if #(.NM(NM), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

    rfdc_wb_arbiter #(.NM(NM), .ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT(TO)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .bus          (bus),
        .bridge_err_i (bridge),
        .grant_o      (grant),
        .timeout_o    (tmo),
        .err_count_o  (ecnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Upstream master state as driven by the bench
    logic          mreq [NM];
    logic          mwe  [NM];
    logic [AB-1:0] madr [NM];
    logic [DB-1:0] mdat [NM];
    logic [SB-1:0] msel [NM];

    // Reference model: round-robin pointer and error counter
    int ptr_m  = 0;
    int ecnt_m = 0;

    typedef struct {
        logic [1:0]    req;
        logic [AB-1:0] adr0;
        logic [AB-1:0] adr1;
        logic          we;
        int            lat;
        int            resp;   // 0 ack, 1 err, 2 ack+err, 3 none
        logic [DB-1:0] rdata;
        int            own;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_masters();
        for (int k = 0; k < NM; k++) begin
            bus.m_cyc_i[k]            = mreq[k];
            bus.m_stb_i[k]            = mreq[k];
            bus.m_we_i[k]             = mwe[k];
            bus.m_adr_i[k*AB +: AB]   = madr[k];
            bus.m_dat_i[k*DB +: DB]   = mdat[k];
            bus.m_sel_i[k*SB +: SB]   = msel[k];
        end
    endtask

    task automatic set_master(input int k, input logic we, input logic [AB-1:0] adr);
        mreq[k] = 1'b1;
        mwe[k]  = we;
        madr[k] = adr;
        mdat[k] = 32'hC0DE0000 ^ {14'h0, adr};
        msel[k] = adr[5:2] | 4'h1;
    endtask

    function automatic int rr_pick();
        for (int i = 0; i < NM; i++) begin
            int idx = (ptr_m + i) % NM;
            if (mreq[idx]) return idx;
        end
        return -1;
    endfunction

    // Requests already set up in mreq; DUT idle. Ends just after the edge that
    // raised the slave strobe.
    task automatic txn_start(input int own);
        int n;
        n = 0;
        drive_masters();
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.s_stb_o && n < 4);
        check("stb_latency", 64'(n), 64'd1);
        check("grant", 64'(grant), 64'd1 << own);
        check("s_cyc", 64'(bus.s_cyc_o), 64'd1);
        check("s_adr", 64'(bus.s_adr_o), 64'(madr[own]));
        check("s_we", 64'(bus.s_we_o), 64'(mwe[own]));
        check("s_dat", 64'(bus.s_dat_o), 64'(mdat[own]));
        check("s_sel", 64'(bus.s_sel_o), 64'(msel[own]));
    endtask

    task automatic txn_finish(input int own, input int lat, input int resp,
                              input logic [DB-1:0] rdata, input logic br, input logic absorbed);
        logic [NM-1:0] bit_own;
        bit_own = NM'(1) << own;
        if (resp == 3) begin
            repeat (TO) @(posedge clk);
            #1;
            check("wdog_stb_hold", 64'(bus.s_stb_o), 64'd1);
            check("wdog_no_early", 64'(tmo), 64'd0);
            @(posedge clk); #1;
            check("wdog_stb_drop", 64'(bus.s_cyc_o), 64'd0);
            check("wdog_timeout", 64'(tmo), 64'd1);
            check("wdog_m_err", 64'(bus.m_err_o), absorbed ? 64'd0 : 64'(bit_own));
            check("wdog_m_ack", 64'(bus.m_ack_o), 64'd0);
        end else begin
            repeat (lat) @(posedge clk);
            #1;
            bus.s_ack_i = (resp != 1);
            bus.s_err_i = (resp != 0);
            bus.s_dat_i = rdata;
            @(posedge clk); #1;
            bus.s_ack_i = 1'b0;
            bus.s_err_i = 1'b0;
            bus.s_dat_i = $urandom;
            check("m_ack", 64'(bus.m_ack_o), (!absorbed && resp == 0) ? 64'(bit_own) : 64'd0);
            check("m_err", 64'(bus.m_err_o), (!absorbed && resp != 0) ? 64'(bit_own) : 64'd0);
            check("m_dat", 64'(bus.m_dat_o), 64'(rdata));
            check("s_stb_drop", 64'(bus.s_stb_o), 64'd0);
            check("no_timeout", 64'(tmo), 64'd0);
        end
        // RELEASE cycle: optional bridge error, owner finishes its cycle
        bridge    = br;
        mreq[own] = 1'b0;
        drive_masters();
        ptr_m = (own + 1) % NM;
        if ((resp == 3 || br) && ecnt_m < 65535) ecnt_m++;
        @(posedge clk); #1;
        bridge = 1'b0;
        check("pulse_one_cycle", 64'({bus.m_ack_o, bus.m_err_o, tmo}), 64'd0);
        check("grant_idle", 64'(grant), 64'd0);
        check("err_count", 64'(ecnt), 64'(ecnt_m));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 64'(grant), 64'd0);
        check({tag, "_s_ctl"}, 64'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o}), 64'd0);
        check({tag, "_s_adr"}, 64'(bus.s_adr_o), 64'd0);
        check({tag, "_s_dat"}, 64'(bus.s_dat_o), 64'd0);
        check({tag, "_s_sel"}, 64'(bus.s_sel_o), 64'd0);
        check({tag, "_m_resp"}, 64'({bus.m_ack_o, bus.m_err_o, tmo}), 64'd0);
        check({tag, "_m_dat"}, 64'(bus.m_dat_o), 64'd0);
        check({tag, "_err_count"}, 64'(ecnt), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int own, r, resp;
        logic any;

        for (int k = 0; k < NM; k++) begin
            mreq[k] = 1'b0; mwe[k] = 1'b0; madr[k] = '0; mdat[k] = '0; msel[k] = '0;
        end
        drive_masters();
        bus.s_ack_i = 1'b0;
        bus.s_err_i = 1'b0;
        bus.s_dat_i = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // table: req, adr0, adr1, we, lat, resp, rdata, expected owner
        tbl[0] = '{2'b01, 18'h00004, 18'h00000, 1'b0, 3, 0, 32'hDEADBEEF, 0};
        tbl[1] = '{2'b11, 18'h00010, 18'h01020, 1'b1, 1, 0, 32'h11111111, 1};
        tbl[2] = '{2'b11, 18'h00030, 18'h01040, 1'b0, 2, 0, 32'h22222222, 0};
        tbl[3] = '{2'b11, 18'h00050, 18'h01060, 1'b1, 4, 0, 32'h33333333, 1};
        tbl[4] = '{2'b11, 18'h00070, 18'h01080, 1'b0, 1, 0, 32'h44444444, 0};
        tbl[5] = '{2'b10, 18'h00000, 18'h3FFFC, 1'b1, 2, 2, 32'h55555555, 1};
        tbl[6] = '{2'b10, 18'h00000, 18'h20000, 1'b0, 2, 1, 32'h66666666, 1};
        tbl[7] = '{2'b01, 18'h3FFFF, 18'h00000, 1'b1, 1, 0, 32'h77777777, 0};
        tbl[8] = '{2'b01, 18'h12345, 18'h00000, 1'b0, 5, 0, 32'h88888888, 0};

        for (int v = 0; v < 9; v++) begin
            for (int k = 0; k < NM; k++) begin
                if (tbl[v].req[k] && !mreq[k]) set_master(k, tbl[v].we, (k == 0) ? tbl[v].adr0 : tbl[v].adr1);
            end
            txn_start(tbl[v].own);
            txn_finish(tbl[v].own, tbl[v].lat, tbl[v].resp, tbl[v].rdata, 1'b0, 1'b0);
        end

        // three isolated bridge error pulses
        for (int i = 0; i < 3; i++) begin
            bridge = 1'b1;
            @(posedge clk); #1;
            bridge = 1'b0;
            @(posedge clk); #1;
        end
        ecnt_m += 3;
        check("bridge_count3", 64'(ecnt), 64'd3);

        // watchdog with a bridge error coinciding with timeout_o, then a late ack
        set_master(0, 1'b0, 18'h00100);
        txn_start(0);
        txn_finish(0, 0, 3, '0, 1'b1, 1'b0);
        bus.s_ack_i = 1'b1;
        @(posedge clk); #1;
        bus.s_ack_i = 1'b0;
        check("late_ack_ignored", 64'(bus.m_ack_o), 64'd0);
        check("late_ack_no_stb", 64'(bus.s_stb_o), 64'd0);
        @(posedge clk); #1;
        check("late_ack_still_0", 64'(bus.m_ack_o), 64'd0);

        // master 1 abandons its cycle during WAIT; master 0 queues meanwhile
        set_master(1, 1'b0, 18'h00200);
        txn_start(1);
        @(posedge clk); #1;
        mreq[1] = 1'b0;
        set_master(0, 1'b1, 18'h00300);
        drive_masters();
        txn_finish(1, 4, 0, 32'hABCD0123, 1'b0, 1'b1);
        txn_start(0);
        txn_finish(0, 1, 0, 32'h0BADF00D, 1'b0, 1'b0);

        // reset while in WAIT with pointer at 1
        set_master(1, 1'b1, 18'h00400);
        txn_start(1);
        @(posedge clk); #1;
        mreq[1] = 1'b0;
        drive_masters();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_all_zero("midreset");
        ecnt_m = 0;
        ptr_m  = 0;
        set_master(0, 1'b0, 18'h00500);
        set_master(1, 1'b0, 18'h00600);
        txn_start(0);
        txn_finish(0, 2, 0, 32'h5A5A5A5A, 1'b0, 1'b0);

        // randomized traffic against the round-robin model
        for (int it = 0; it < 40; it++) begin
            any = 1'b0;
            for (int k = 0; k < NM; k++) begin
                if (!mreq[k] && $urandom_range(0, 1) == 1)
                    set_master(k, 1'($urandom_range(0, 1)), AB'($urandom));
                any = any | mreq[k];
            end
            if (!any) set_master($urandom_range(0, NM - 1), 1'($urandom_range(0, 1)), AB'($urandom));
            own  = rr_pick();
            r    = $urandom_range(0, 9);
            resp = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : 3;
            txn_start(own);
            txn_finish(own, $urandom_range(1, 5), resp, $urandom, ($urandom_range(0, 3) == 0), 1'b0);
        end

        // saturation of err_count_o with bridge_err_i held high
        for (int k = 0; k < NM; k++) mreq[k] = 1'b0;
        drive_masters();
        bridge = 1'b1;
        repeat (65534 - ecnt_m) @(posedge clk);
        #1;
        check("err_count_fffe", 64'(ecnt), 64'hFFFE);
        @(posedge clk); #1;
        check("err_count_ffff", 64'(ecnt), 64'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        check("err_count_sat", 64'(ecnt), 64'hFFFF);
        bridge = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rfdc_wb_arbiter.md
Name: rfdc_wb_arbiter

Overview:
- Shares the single Wishbone register port of the RFDC wrapper between NM Wishbone masters. Typical masters are the housekeeping/serial-command path and an auto-configuration sequencer.
- Arbitration is round-robin, one transaction per grant.
- Transactions are fully registered.
- A watchdog timeout protects against a hung WB->AXI bridge or RFDC AXI-Lite port.
- Sits in the wb_clk_i domain, directly in front of the RFDC wrapper's WB target port.

Parameters:
NM, 2, number of requesting masters (1..8)
ADDR_BITS, 18, Wishbone address width
DATA_BITS, 32, Wishbone data width
TIMEOUT, 1023, wb_clk_i cycles from slave strobe to forced abort (>=4)

Ports:
wb_clk_i  in  1  clock, all logic
wb_rst_i  in  1  reset
m_cyc_i  in  NM  per-master cycle
m_stb_i  in  NM  per-master strobe
m_we_i  in  NM  per-master write enable
m_adr_i  in  NM*ADDR_BITS  per-master address, master k at [k*ADDR_BITS +: ADDR_BITS]
m_dat_i  in  NM*DATA_BITS  per-master write data, same packing
m_sel_i  in  NM*(DATA_BITS/8)  per-master byte selects
m_dat_o  out  DATA_BITS  read data, shared by all masters
m_ack_o  out  NM  per-master ack
m_err_o  out  NM  per-master error
s_cyc_o  out  1  to RFDC WB target
s_stb_o  out  1  to RFDC WB target
s_we_o  out  1  to RFDC WB target
s_adr_o  out  ADDR_BITS  to RFDC WB target
s_dat_o  out  DATA_BITS  to RFDC WB target
s_sel_o  out  DATA_BITS/8  to RFDC WB target
s_dat_i  in  DATA_BITS  from RFDC WB target
s_ack_i  in  1  from RFDC WB target
s_err_i  in  1  from RFDC WB target
bridge_err_i  in  1  bridge error pulse from the RFDC wrapper
grant_o  out  NM  one-hot current owner; 0 when idle
timeout_o  out  1  one-cycle pulse on watchdog abort
err_count_o  out  16  saturating count of timeouts plus bridge errors

Behaviour:
- Interface: single clock wb_clk_i; wb_rst_i is synchronous, active-high.

Reset values:
- State IDLE.
- All outputs 0.
- Round-robin pointer 0, so master 0 has first priority.
- err_count_o 0.
- Watchdog counter 0.

State machine (IDLE, ISSUE, WAIT, RELEASE):
- IDLE:
  - Request from master k = m_cyc_i[k] & m_stb_i[k].
  - Pick the first requesting index at or after the pointer, modulo NM.
  - Latch that master's we/adr/dat/sel into the s_* registers and set grant_o one-hot.
  - Go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - s_cyc_o and s_stb_o are asserted from this cycle, i.e. one cycle after the request was sampled in IDLE.
  - Go to WAIT and clear the watchdog.
- WAIT:
  - s_cyc_o and s_stb_o are held, with s_* fields stable, until s_ack_i or s_err_i.
  - On s_ack_i or s_err_i:
    - Deassert s_cyc_o and s_stb_o on the next edge.
    - Register s_dat_i into m_dat_o.
    - Pulse m_ack_o[owner] (on ack) or m_err_o[owner] (on err) for exactly one cycle, one cycle after the slave response.
    - Go to RELEASE.
  - If s_ack_i and s_err_i are high together, err takes precedence.
- RELEASE:
  - grant_o cleared.
  - Pointer set to (owner+1) mod NM.
  - Go to IDLE.
  - No new grant is issued in this cycle.
  - Minimum transaction spacing is therefore 4 cycles plus the slave latency.

Watchdog:
- Counts every cycle spent in WAIT.
- When the count reaches TIMEOUT with no slave response:
  - Deassert s_cyc_o and s_stb_o.
  - Pulse m_err_o[owner] and timeout_o.
  - Increment err_count_o.
  - Go to RELEASE.
- A late s_ack_i or s_err_i arriving in IDLE or RELEASE is ignored and not forwarded.

Master abort:
- If the owner drops m_cyc_i during ISSUE or WAIT, the slave cycle continues to completion; it is not aborted because the AXI side cannot cancel.
- The response is absorbed: no m_ack_o or m_err_o is issued.
- The FSM then proceeds through RELEASE normally.

Non-owner masters:
- They see no ack or err and must hold their request.
- Their requests are sampled only in IDLE.

err_count_o:
- Increments by 1 per cycle in which timeout_o or bridge_err_i is high.
- If both are high in the same cycle, it increments by 1 only.
- Saturates at 16'hFFFF.
- Cleared only by reset.

Reset mid-transaction:
- Immediately returns to IDLE with all outputs 0.
- The pointer returns to 0.

NM=1:
- Degenerates to a registered pass-through with the watchdog still active.

Test Plan:
- Single read: master 0 reads 0x00004 and the slave acks 3 cycles after s_stb_o with data 0xDEADBEEF -> s_stb_o is high 1 cycle after the request; m_ack_o[0] pulses once; m_dat_o = 0xDEADBEEF; m_ack_o[1] stays 0.
- Simultaneous requests: both masters request continuously with the pointer at 0 -> grants alternate 0,1,0,1 over 4 transactions; each grant_o is one-hot; s_adr_o matches the owner's address.
- Watchdog: TIMEOUT=8 and the slave never acks -> after 8 WAIT cycles, s_cyc_o falls; m_err_o[owner] and timeout_o pulse once; err_count_o = 1; a late s_ack_i 2 cycles later produces no m_ack_o.
- Master abort: master 1 drops m_cyc_i during WAIT and the slave acks 5 cycles later -> no m_ack_o[1]; the next grant goes to master 0 in the following IDLE.
- Error precedence and counter: s_ack_i and s_err_i asserted together, plus bridge_err_i pulsed 3 times -> m_err_o pulses rather than m_ack_o; err_count_o = 3; forcing the count to 0xFFFF then pulsing bridge_err_i holds 0xFFFF.
- Reset in WAIT: assert wb_rst_i for 1 cycle mid-transaction -> next cycle all outputs are 0, grant_o = 0, and master 0 gets the first grant afterwards.
